// File: rtl/shiftreg_deser.sv
// Serial-to-parallel receiver: frames an MSB-first bit stream into WIDTH-bit words
// using a sync marker and hands them out through a one-entry valid/ready buffer.
module shiftreg_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_bit,
   input  logic             i_bit_en,
   input  logic             i_sync,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_overrun,
   input  logic             i_clr_overrun,
   output logic             o_frame_err
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [CW-1:0]    cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
   logic [WIDTH-1:0] shift_in_s;
   logic [WIDTH-1:0] data_r, data_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic             overrun_r, overrun_nxt_s;
   logic             frame_err_r, frame_err_nxt_s;
   logic             complete_s;
   logic             drop_s;

   assign shift_in_s = {shreg_r[WIDTH-2:0], i_bit};

   // Framing state machine and shift register next-state
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      shreg_nxt_s     = shreg_r;
      frame_err_nxt_s = 1'b0;
      complete_s      = 1'b0;
      case (state_r)
         HUNT: begin
            if (i_bit_en && i_sync) begin
               shreg_nxt_s = {{(WIDTH-1){1'b0}}, i_bit};
               cnt_nxt_s   = CNT_ONE;
               state_nxt_s = COLLECT;
            end else begin
               state_nxt_s = HUNT;
            end
         end
         COLLECT: begin
            if (i_bit_en && i_sync) begin
               // A sync at a word boundary is a normal start; mid-word it is an error
               shreg_nxt_s     = {{(WIDTH-1){1'b0}}, i_bit};
               cnt_nxt_s       = CNT_ONE;
               frame_err_nxt_s = (cnt_r != CNT_ZERO);
            end else if (i_bit_en) begin
               shreg_nxt_s = shift_in_s;
               if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s  = CNT_ZERO;
                  complete_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            state_nxt_s = HUNT;
            cnt_nxt_s   = CNT_ZERO;
            shreg_nxt_s = {WIDTH{1'b0}};
         end
      endcase
   end

   // Output buffer load/drain and overrun flag next-state
   always_comb begin
      data_nxt_s    = data_r;
      valid_nxt_s   = valid_r;
      drop_s        = 1'b0;
      overrun_nxt_s = overrun_r;
      if (complete_s) begin
         if (!valid_r || i_ready) begin
            data_nxt_s  = shift_in_s;
            valid_nxt_s = 1'b1;
         end else begin
            drop_s = 1'b1;
         end
      end else if (valid_r && i_ready) begin
         valid_nxt_s = 1'b0;
      end else begin
         valid_nxt_s = valid_r;
      end
      if (drop_s) begin
         overrun_nxt_s = 1'b1;
      end else if (i_clr_overrun) begin
         overrun_nxt_s = 1'b0;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= HUNT;
         cnt_r       <= CNT_ZERO;
         shreg_r     <= {WIDTH{1'b0}};
         data_r      <= {WIDTH{1'b0}};
         valid_r     <= 1'b0;
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         shreg_r     <= shreg_nxt_s;
         data_r      <= data_nxt_s;
         valid_r     <= valid_nxt_s;
         overrun_r   <= overrun_nxt_s;
         frame_err_r <= frame_err_nxt_s;
      end
   end

   assign o_data      = data_r;
   assign o_valid     = valid_r;
   assign o_overrun   = overrun_r;
   assign o_frame_err = frame_err_r;

endmodule

// File: doc/shiftreg_deser.md
Name: shiftreg_deser

Overview:
Serial-to-parallel receiver that sits directly downstream of the shiftreg serializer. It consumes the serializer's o_out bit stream, which is MSB first, one bit per qualified clock. It frames the stream into WIDTH-bit words using a sync marker and presents each word on a valid/ready parallel interface through a one-entry output buffer. It reports overruns and framing errors.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
i_bit  input  1  serial data bit (from serializer o_out)
i_bit_en  input  1  i_bit is valid this cycle
i_sync  input  1  qualified by i_bit_en: the current bit is the MSB of a new word
o_data  output  WIDTH  assembled word, MSB = first received bit
o_valid  output  1  o_data holds an unconsumed word
i_ready  input  1  consumer accepts o_data when o_valid && i_ready
o_overrun  output  1  sticky: a completed word was dropped
i_clr_overrun  input  1  synchronous clear of o_overrun
o_frame_err  output  1  one-cycle pulse: sync arrived mid-word

Behaviour:
- Reset (rst_n=0, async):
  - State goes to HUNT; bit counter and shift register go to 0.
  - o_data=0, o_valid=0, o_overrun=0, o_frame_err=0.
  - Outputs hold these values while rst_n is low.
- State HUNT:
  - Bits are ignored until i_bit_en && i_sync.
  - That bit is shifted in as the MSB, the counter is set to 1, and the state goes to COLLECT.
- State COLLECT, on i_bit_en && !i_sync:
  - shreg <= {shreg[WIDTH-2:0], i_bit}.
  - cnt <= cnt+1.
- Word completion (in COLLECT): the bit with i_bit_en && cnt==WIDTH-1 completes the word.
  - cnt returns to 0 and the state stays COLLECT.
  - Following words need no sync.
  - Latency: o_valid rises and o_data updates on the rising edge that samples the last bit, i.e. they are visible in the cycle after that bit is presented.
- Output buffer:
  - A completed word loads o_data and sets o_valid if the buffer is empty (o_valid=0) or is being drained in the same cycle (o_valid && i_ready). Simultaneous drain and load yields o_valid=1 with the new word.
  - Otherwise the word is dropped, o_data is unchanged, and o_overrun is set.
  - o_valid clears on o_valid && i_ready when no new word completes.
  - o_data is stable while o_valid && !i_ready.
- Sync in COLLECT: i_bit_en && i_sync in COLLECT restarts framing. The bit becomes the MSB and cnt becomes 1.
  - If cnt != 0, the partial word is discarded and o_frame_err pulses high for exactly one cycle (registered).
  - If cnt == 0 (word boundary), it is a normal word start with no error.
- i_sync without i_bit_en: ignored in all states.
- Overrun flag:
  - o_overrun stays set until a cycle with i_clr_overrun=1 and no new drop event.
  - Set has priority over clear in the same cycle.
- Counter width: $clog2(WIDTH)+1 bits. Counter values >= WIDTH are unreachable.
- Reset mid-word: the partial word and any buffered word are lost with no error flags. The block returns to HUNT and needs a new sync.

Test Plan:
- Reset, then feed 10011010 MSB first with i_bit_en=1, i_sync=1 on the first bit, i_ready=1 -> o_valid=1 for one cycle with o_data=8'h9A, the cycle after the 8th bit; o_overrun=0, o_frame_err=0.
- Before any sync, feed 16 bits with i_bit_en=1 and i_sync=0 -> o_valid never asserts; the block stays in HUNT.
- Sync, then words 8'hA5 and 8'h3C back-to-back with no further sync, i_ready=0 -> o_data=8'hA5 held with o_valid=1; the second word is dropped and o_overrun=1. Then i_ready=1 for one cycle -> o_valid=0. Then i_clr_overrun=1 -> o_overrun=0.
- Word 8'hFF completes while o_valid=1 holding 8'h00, with i_ready=1 in the same cycle -> next cycle o_valid=1, o_data=8'hFF, o_overrun=0.
- Sync, 3 bits, then sync again followed by 8'h5A -> o_frame_err high for exactly 1 cycle; then o_data=8'h5A with o_valid=1.
- Assert rst_n=0 asynchronously mid-word with o_valid=1 -> all outputs 0 immediately. After release, bits without sync produce no output.
